// File: rtl/shift_seq_ctrl.sv
// Iterative RV32 shift sequencer: one 1-bit step per cycle (or 4-bit when
// SHIFT_SEQ_STEP4_EN is defined), with valid/ready on both sides.
module shift_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_right,
    input  logic               in_arith,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               right_q, right_d;
    logic               arith_q, arith_d;

    logic               use4;
    logic               fill;
    logic [SHAMT_W-1:0] step;
    logic [XLEN-1:0]    shifted;

`ifdef SHIFT_SEQ_STEP4_EN
    assign use4 = (count_q >= SHAMT_W'(4));
`else
    assign use4 = 1'b0;
`endif

    // Sign bit never changes during an arithmetic right shift, so the
    // live MSB is the latched sign.
    assign fill = right_q & arith_q & data_q[XLEN-1];
    assign step = use4 ? SHAMT_W'(4) : SHAMT_W'(1);

    always_comb begin
        shifted = data_q;
        if (use4) begin
            if (right_q)
                shifted = {{4{fill}}, data_q[XLEN-1:4]};
            else
                shifted = {data_q[XLEN-5:0], 4'b0000};
        end else begin
            if (right_q)
                shifted = {fill, data_q[XLEN-1:1]};
            else
                shifted = {data_q[XLEN-2:0], 1'b0};
        end
    end

    assign in_ready  = (state_q == IDLE) & ~flush;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        right_d = right_q;
        arith_d = arith_q;
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        count_d = in_shamt;
                        right_d = in_right;
                        arith_d = in_arith;
                        state_d = (in_shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_d  = shifted;
                    count_d = count_q - step;
                    if (count_q == step)
                        state_d = DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            right_q <= right_d;
            arith_q <= arith_d;
        end
    end

endmodule
